// File: rtl/irq_ctrl_pkg.sv
// rtl/irq_ctrl_pkg.sv - register map and shared constants for the interrupt controller
package irq_ctrl_pkg;

    typedef enum logic [1:0] {
        IRQ_VEC  = 2'd0,
        IRQ_PEND = 2'd1,
        IRQ_EN   = 2'd2,
        IRQ_MODE = 2'd3
    } irq_reg_e;

    localparam int VEC_VALID_BIT = 31;
    localparam int IDX_W         = 5;

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - lowest-index-first priority encoder, purely combinational
module irq_prio_enc
    import irq_ctrl_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]     vec_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                valid_o = 1'b1;
                idx_o   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - N-source edge/level interrupt controller with a priority vector register
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stb,
    input  logic         we,
    input  logic [1:0]   addr,
    input  logic [31:0]  data_in,
    output logic [31:0]  data_out,
    output logic         ack,
    input  logic [N-1:0] irq_in,
    output logic         irq
);

    logic [N-1:0] in_q_q, in_prev_q, pend_q, en_q, mode_q;
    logic [N-1:0] pend_d, en_d, mode_d;
    logic [N-1:0] rise, eff_pend, act, wdata, w1c;
    logic         irq_q, irq_d;
    logic         wr;
    logic         prio_valid;
    logic [IDX_W-1:0] prio_idx;
    irq_reg_e     reg_sel;

    assign reg_sel  = irq_reg_e'(addr);
    assign wr       = stb & we;
    assign wdata    = data_in[N-1:0];
    assign ack      = stb;

    generate
        if (N < 32) begin : g_unused_hi
            logic unused_data_hi;
            assign unused_data_hi = ^data_in[31:N];
        end
    endgenerate

    assign rise     = in_q_q & ~in_prev_q;
    assign eff_pend = (mode_q & pend_q) | (~mode_q & in_q_q);
    assign act      = eff_pend & en_q;

    always_comb begin
        en_d   = (wr && reg_sel == IRQ_EN)   ? wdata : en_q;
        mode_d = (wr && reg_sel == IRQ_MODE) ? wdata : mode_q;
        w1c    = (wr && reg_sel == IRQ_PEND) ? wdata : '0;
        // Set beats clear; masking with the new mode clears pend as a bit goes level.
        pend_d = ((pend_q & ~w1c) | rise) & mode_d;
        irq_d  = |act;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_q_q    <= '0;
            in_prev_q <= '0;
            pend_q    <= '0;
            en_q      <= '0;
            mode_q    <= '0;
            irq_q     <= 1'b0;
        end else begin
            in_q_q    <= irq_in;
            in_prev_q <= in_q_q;
            pend_q    <= pend_d;
            en_q      <= en_d;
            mode_q    <= mode_d;
            irq_q     <= irq_d;
        end
    end

    assign irq = irq_q;

    irq_prio_enc #(.N(N)) u_prio (
        .vec_i   (act),
        .valid_o (prio_valid),
        .idx_o   (prio_idx)
    );

    always_comb begin
        data_out = '0;
        case (reg_sel)
            IRQ_VEC:  data_out = (32'(prio_valid) << VEC_VALID_BIT) | 32'(prio_idx);
            IRQ_PEND: data_out = 32'(eff_pend);
            IRQ_EN:   data_out = 32'(en_q);
            IRQ_MODE: data_out = 32'(mode_q);
            default:  data_out = '0;
        endcase
    end

endmodule
